// File: rtl/bias_loader_if.sv
// Bias loader bus: the byte stream that feeds the loader (s_*) and the
// bias memory write port that it drives (wr_*).
// The loader uses the slave modport. The host/config stream and the bias
// memory use the master modport.
interface bias_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/bias_loader.sv
// Bias memory writer.
// Accepts signed 8-bit bias bytes over a valid/ready stream. Each accepted
// byte becomes one registered write to the bias memory at address
// {layer[1:0], neuron[3:0]}. Biases are written in layer/neuron order.
// Each start pulse runs one load.
// Optional feature: macro BIAS_LOADER_CKSUM_EN. After the last bias, one
// extra byte is taken and compared with the mod-256 sum of all the biases.
// A mismatch sets cksum_err. The checksum byte is never written to memory.
module bias_loader #(
  parameter int NUM_LAYERS = 3,
  parameter int NEURONS_L0 = 2,
  parameter int NEURONS_L1 = 2,
  parameter int NEURONS_L2 = 1,
  parameter int NEURONS_L3 = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  bias_loader_if.slave    bus,
  output logic            busy,
  output logic            done,
  output logic            cksum_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2
`ifdef BIAS_LOADER_CKSUM_EN
    , S_CKSUM = 2'd3
`endif
  } state_t;

  localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);

  state_t     state, state_next;
  logic [1:0] layer;
  logic [3:0] neuron;
  logic       accept;
  logic       last_bias;

  // Index of the last neuron in a given layer.
  function automatic logic [3:0] last_neuron(input logic [1:0] l);
    logic [3:0] n;
    n = 4'(NEURONS_L0 - 1);
    case (l)
      2'd1:    n = 4'(NEURONS_L1 - 1);
      2'd2:    n = 4'(NEURONS_L2 - 1);
      2'd3:    n = 4'(NEURONS_L3 - 1);
      default: n = 4'(NEURONS_L0 - 1);
    endcase
    return n;
  endfunction

  assign accept    = bus.s_valid && bus.s_ready;
  assign last_bias = (layer == LAST_LAYER) && (neuron == last_neuron(layer));

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments only. Every
  // flop then samples values from before the edge, whatever the order the
  // blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Abort wins over an accept in the same cycle.
  // NOTE: state_next gets a default before the case. Every path then assigns
  // it, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_LOAD;
      S_LOAD: begin
        if (abort) state_next = S_IDLE;
        else if (accept && last_bias)
`ifdef BIAS_LOADER_CKSUM_EN
          state_next = S_CKSUM;
`else
          state_next = S_DONE;
`endif
      end
`ifdef BIAS_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (abort)       state_next = S_IDLE;
        else if (accept) state_next = S_DONE;
      end
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state alone. s_ready does not look at
  // s_valid.
  always_comb begin
    bus.s_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_LOAD:  begin bus.s_ready = 1'b1; busy = 1'b1; end
`ifdef BIAS_LOADER_CKSUM_EN
      S_CKSUM: begin bus.s_ready = 1'b1; busy = 1'b1; end
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: layer/neuron cursor and the registered write port.
  // The write strobe is high only in the cycle after an accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer       <= 2'd0;
      neuron      <= 4'd0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= 6'd0;
      bus.wr_data <= 8'd0;
    end else begin
      bus.wr_en <= 1'b0;
      if (state == S_IDLE && start) begin
        layer  <= 2'd0;
        neuron <= 4'd0;
      end
      if (state == S_LOAD && accept && !abort) begin
        bus.wr_en   <= 1'b1;
        bus.wr_addr <= {layer, neuron};
        bus.wr_data <= bus.s_data;
        if (neuron == last_neuron(layer)) begin
          neuron <= 4'd0;
          layer  <= layer + 2'd1;
        end else begin
          neuron <= neuron + 4'd1;
        end
      end
    end
  end

`ifdef BIAS_LOADER_CKSUM_EN
  logic [7:0] sum;

  // Running mod-256 sum of the written biases, and the sticky mismatch flag.
  // Both are cleared by start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= 8'd0;
      cksum_err <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        sum       <= 8'd0;
        cksum_err <= 1'b0;
      end
      if (state == S_LOAD && accept && !abort)
        sum <= sum + bus.s_data;
      if (state == S_CKSUM && accept && !abort && bus.s_data != sum)
        cksum_err <= 1'b1;
    end
  end
`else
  assign cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_bias_loader.sv
// Directed testbench for bias_loader (default parameters: 2/2/1 neurons).
// The checksum tests are compiled in when BIAS_LOADER_CKSUM_EN is defined.
module tb_bias_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic cksum_err;

  bias_loader_if bus ();

  bias_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .cksum_err (cksum_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_addr [5] = '{6'h00, 6'h01, 6'h10, 6'h11, 6'h20};
  logic [7:0] vec [5];

  logic [5:0] q_addr [$];
  logic [7:0] q_data [$];
  int         done_cnt;

  // Write-port monitor, sampled on the negedge while the outputs are stable.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      q_addr.push_back(bus.wr_addr);
      q_data.push_back(bus.wr_data);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    done_cnt = 0;
  endtask

  // Idle for 'gap' cycles, checking that no write happens during the gap.
  // Then present one byte, which is accepted at the next posedge.
  task automatic push_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      bus.s_valid = 1'b0;
      @(negedge clk);
      check("gap_wr_en", bus.wr_en, 1'b0);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    check("s_ready", bus.s_ready, 1'b1);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // Load the five biases in vec[] and check the written addresses and data,
  // the done pulse and the checksum flag.
  task automatic run_load(input int gap, input bit hold_start,
                          input logic [7:0] ck_delta, input string tag);
    logic [7:0] sum;
    logic [7:0] got_d;
    logic [5:0] got_a;
    sum = 8'd0;
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = hold_start;
    check({tag, "_busy_load"}, busy, 1'b1);
    for (int i = 0; i < 5; i++) begin
      push_byte(vec[i], gap);
      sum = sum + vec[i];
    end
`ifdef BIAS_LOADER_CKSUM_EN
    push_byte(sum + ck_delta, gap);
    check({tag, "_cksum_err"}, cksum_err, (ck_delta != 8'd0));
`else
    check({tag, "_last_wr_en"}, bus.wr_en, 1'b1);
    check({tag, "_last_addr"}, bus.wr_addr, 6'h20);
    check({tag, "_cksum_err"}, cksum_err, 1'b0);
`endif
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_ready_done"}, bus.s_ready, 1'b0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_busy_idle"}, busy, 1'b0);
    check({tag, "_ready_idle"}, bus.s_ready, 1'b0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_n_writes"}, q_addr.size(), 5);
    for (int i = 0; i < 5; i++) begin
      got_a = (q_addr.size() > i) ? q_addr[i] : 6'bx;
      got_d = (q_data.size() > i) ? q_data[i] : 8'bx;
      check({tag, "_addr"}, got_a, exp_addr[i]);
      check({tag, "_data"}, got_d, vec[i]);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    clear_log();

    // Reset state.
    #1;
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_wr_addr", bus.wr_addr, 6'h00);
    check("rst_wr_data", bus.wr_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cksum_err", cksum_err, 1'b0);
    check("rst_s_ready", bus.s_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back stream 5, -3, 127, -128, 9.
    vec = '{8'h05, 8'hFD, 8'h7F, 8'h80, 8'h09};
    run_load(0, 1'b0, 8'd0, "b2b");

    // Same stream with two idle cycles before each byte.
    run_load(2, 1'b0, 8'd0, "gap");

    // Abort after two accepted bytes. A byte presented with abort is dropped.
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push_byte(8'h11, 0);
    push_byte(8'h22, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h33;
    abort       = 1'b1;
    @(negedge clk);
    abort       = 1'b0;
    bus.s_valid = 1'b0;
    check("abort_wr_en", bus.wr_en, 1'b0);
    check("abort_ready", bus.s_ready, 1'b0);
    check("abort_busy", busy, 1'b0);
    @(negedge clk);
    check("abort_n_writes", q_addr.size(), 2);
    check("abort_addr0", (q_addr.size() > 0) ? q_addr[0] : 6'bx, 6'h00);
    check("abort_addr1", (q_addr.size() > 1) ? q_addr[1] : 6'bx, 6'h01);
    check("abort_no_done", done_cnt, 0);

    // Start and abort together in IDLE: the load starts.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort2_busy", busy, 1'b0);

    // Reload after abort starts from address 0x00.
    vec = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load(0, 1'b0, 8'd0, "reload");

    // Async reset after three bytes. The 4th byte is not accepted.
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push_byte(8'hA1, 0);
    push_byte(8'hA2, 0);
    push_byte(8'hA3, 0);
    check("pre_rst_wr_en", bus.wr_en, 1'b1);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA4;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", bus.wr_en, 1'b0);
    check("mid_rst_wr_addr", bus.wr_addr, 6'h00);
    check("mid_rst_wr_data", bus.wr_data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", bus.s_ready, 1'b0);
    check("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_wr_en", bus.wr_en, 1'b0);
    check("post_rst_ready", bus.s_ready, 1'b0);
    bus.s_valid = 1'b0;
    check("post_rst_n_writes", q_addr.size(), 3);

    // Start held high through LOAD and DONE: no restart until IDLE.
    vec = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    run_load(0, 1'b1, 8'd0, "hold");
    clear_log();
    @(negedge clk);
    start = 1'b0;
    check("hold_restart_busy", busy, 1'b1);
    push_byte(8'h7E, 0);
    check("hold_restart_addr", (q_addr.size() > 0) ? q_addr[0] : 6'bx, 6'h00);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("hold_abort_busy", busy, 1'b0);

`ifdef BIAS_LOADER_CKSUM_EN
    // Checksum over biases 1..5 is 15. Send 16 first, then 15 (err clears).
    vec = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load(0, 1'b0, 8'd1, "ck_bad");
    check("ck_err_held", cksum_err, 1'b1);
    run_load(1, 1'b0, 8'd0, "ck_good");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bias_loader.md
Name: bias_loader

Overview:
Writer side of the bias memory interface. Accepts a byte stream of signed 8-bit bias values over a valid/ready handshake and produces the write-port transactions that fill the bias memory. Biases are placed in layer/neuron order using the 6-bit bias address format {layer[1:0], neuron[3:0]}, which is the same address the MLP read path takes from input_addr[15:10]. Sits between the host/config stream and the bias memory write port. Runs once per start pulse.

Parameters:
NUM_LAYERS, 3, number of layers loaded (1..4)
NEURONS_L0, 2, output neurons in layer 0 (1..16)
NEURONS_L1, 2, output neurons in layer 1 (1..16; ignored if NUM_LAYERS<2)
NEURONS_L2, 1, output neurons in layer 2 (1..16; ignored if NUM_LAYERS<3)
NEURONS_L3, 1, output neurons in layer 3 (1..16; ignored if NUM_LAYERS<4)

Ports:
clk  in  1  system clock; all state changes on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a load; sampled only in IDLE
abort  in  1  cancel an in-progress load
s_valid  in  1  stream byte valid
s_data  in  8  signed bias byte
s_ready  out  1  loader can accept a byte
wr_en  out  1  bias memory write strobe
wr_addr  out  6  {layer[1:0], neuron[3:0]}
wr_data  out  8  signed bias value
busy  out  1  high in LOAD/CKSUM
done  out  1  one-cycle pulse at load completion
cksum_err  out  1  checksum mismatch flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async): state=IDLE, layer=0, neuron=0. All outputs are 0: wr_en, wr_addr, wr_data, busy, done, cksum_err. Reset mid-load leaves memory partially written; the loader makes no attempt to restore it.
- States: IDLE, LOAD, CKSUM (macro only), DONE.
- IDLE: s_ready=0, busy=0. When start=1: next state LOAD; layer/neuron cleared; running sum cleared; cksum_err cleared.
- LOAD: s_ready=1 (combinational from state; does not depend on s_valid). A byte is accepted when s_valid && s_ready.
  - Accept: next cycle wr_en=1, wr_addr={layer,neuron}, wr_data=s_data. Write latency is 1 cycle; all write outputs are registered.
  - wr_en is 0 in any cycle that follows a non-accepting cycle, so there is at most one write per accepted byte.
  - After the accept, neuron increments. When neuron==NEURONS_Lk-1: neuron=0 and layer increments.
  - Accepting the final neuron of layer NUM_LAYERS-1 moves to DONE, or to CKSUM when the macro is defined.
  - Addresses never written: neuron >= NEURONS_Lk and layer >= NUM_LAYERS.
  - Defaults: write sequence 0x00, 0x01, 0x10, 0x11, 0x20 (5 bytes).
- DONE: done=1 for exactly one cycle, s_ready=0, then IDLE. The final write strobe and done occur in the same cycle.
- abort=1 in LOAD/CKSUM: next state IDLE, no done pulse. A byte accepted in the same cycle as abort is discarded (no write). abort in IDLE/DONE has no effect.
- start is ignored outside IDLE. If start and abort are both high in IDLE, the load starts.
- wr_* are stable from posedge and are therefore valid at the reader's negedge sampling.
- Stalls: s_valid low for any number of cycles holds layer/neuron with wr_en=0. There is no timeout.

Optional Feature:
Macro BIAS_LOADER_CKSUM_EN.
- Defined: running 8-bit sum (mod 256) of all accepted bias bytes. After the last bias, the loader enters CKSUM with s_ready=1.
  - The next accepted byte is compared to the sum and is not written to memory.
  - On mismatch, cksum_err=1, held until the next start or reset.
  - The loader then goes to DONE (done pulses in both the match and mismatch cases).
- Undefined: no CKSUM state; cksum_err is tied to 0; load ends directly after the last bias.

Test Plan:
- Reset, start, stream 5, -3, 127, -128, 9 with s_valid constant -> writes (0x00,5), (0x01,-3), (0x10,127), (0x11,-128), (0x20,9) on consecutive cycles; done pulses with the last write; busy falls.
- Same stream with s_valid toggled 1,0,0,1,... -> identical write sequence; wr_en=0 during gaps; no duplicate addresses.
- Abort after 2 bytes accepted -> exactly 2 writes (0x00, 0x01); no done; s_ready=0; a second start reloads from address 0x00.
- rst_n pulsed low mid-load (after 3 bytes) -> all outputs 0 immediately (async), state IDLE; the 4th byte presented is not accepted.
- Start held high during LOAD plus a second start in DONE -> no restart during LOAD; a new load begins only once IDLE is reached.
- With BIAS_LOADER_CKSUM_EN, biases 1,2,3,4,5: checksum 15 -> done, cksum_err=0. Checksum 16 -> done, cksum_err=1. Only 5 writes in both cases.
